ternary_neuron_accum: RTL and testbench
=======================================

# ternary_neuron_accum

Sequential ternary-neuron back end that sits directly downstream of the 22-input popcount stages. Each beat carries two 5-bit counts from a pair of popcount22 instances: one for the +1-weighted inputs, one for the −1-weighted inputs. The block accumulates the signed difference over a multi-beat neuron evaluation, applies two thresholds on the last beat, and emits a registered ternary activation through a valid/ready handshake.

## Interface
- CNT_W, 5: width of each popcount input.
- ACC_W, 10: signed accumulator width, in two's complement.
- MAX_BEATS, 8: maximum number of beats per neuron evaluation.
- THR_HI, 3: signed threshold. A sum ≥ THR_HI gives +1.
- THR_LO, −3: signed threshold. A sum ≤ THR_LO gives −1. THR_LO < THR_HI is required.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_last  in  1  final beat of the current neuron.
- pos_cnt  in  CNT_W  popcount of the positively weighted inputs, unsigned.
- neg_cnt  in  CNT_W  popcount of the negatively weighted inputs, unsigned.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts the result.
- out_act  out  2  ternary code: 2'b01 = +1, 2'b11 = −1, 2'b00 = 0. 2'b10 is never driven.
- out_sum  out  ACC_W  final saturated signed sum.
- out_trunc  out  1  the evaluation was force-closed at MAX_BEATS without in_last.

## Operation
- Clocking and reset: one clock. Reset is asynchronous and active-low.
- Beat transfer: a beat is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready.
- Per-beat delta: delta = pos_cnt − neg_cnt, computed at CNT_W+1 bits signed (range −31..+31).
- Accumulation: acc_next = sat(acc + delta). sat() clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1]; no wrap-around.
- FSM with two states:
  - IDLE: acc = 0, beat_cnt = 0.
  - On an accepted beat that is not final: go to ACCUM, acc ← sat(delta), beat_cnt ← 1.
  - ACCUM: each accepted beat adds into acc and increments beat_cnt.
- Final beat: a beat is final when in_last = 1, or when beat_cnt == MAX_BEATS−1, i.e. it is the MAX_BEATS-th beat.
- On an accepted final beat:
  - The sum s = sat(acc + delta) is computed, including the current beat.
  - The output register loads out_sum = s.
  - out_act = +1 if s ≥ THR_HI; else −1 if s ≤ THR_LO; else 0.
  - out_trunc = !in_last. out_valid is set to 1.
  - The FSM returns to IDLE; acc and beat_cnt are cleared.
- Single-beat evaluation: a beat with in_last = 1 accepted in IDLE produces a result from delta alone.
- Stall: while out_valid && !out_ready, in_ready = 0. acc, the FSM and the outputs all hold. Input values are ignored.
- Simultaneous events: if the output is consumed and a new final beat is accepted in the same cycle, the output register reloads with the new result and out_valid stays 1. The old result is consumed exactly once.
- Output clear: if the output is consumed with no new final beat, out_valid goes to 0 on the next edge.
- Reset mid-evaluation: rst_n low discards the partial sum, returns the FSM to IDLE, and drops any pending output.
- Output values while out_valid = 0: out_act, out_sum and out_trunc hold their last values, or their reset values.

## Timing
- Reset values: out_valid = 0, out_act = 2'b00, out_sum = 0, out_trunc = 0, acc = 0, beat_cnt = 0, FSM = IDLE. in_ready = 1 after reset.
- Latency: the result is valid one cycle after the edge on which the final beat is accepted.
- Throughput: one beat per cycle while out_ready = 1. Back-to-back single-beat neurons run at one result per cycle.
- The output registers change only on acceptance of a final beat, or on reset.
- Combinational path: in_ready depends only on out_valid and out_ready. There is no combinational path from in_* to out_*.
- Threshold compare and saturation are done in the accept cycle. This is one adder, one clamp and two comparators; no pipelining is needed.

## Test plan
- Reset and idle: hold rst_n low, then release with no traffic.
  - Required: out_valid = 0, out_act = 00, out_sum = 0, in_ready = 1.
- Three-beat positive evaluation, defaults: beats (pos, neg) = (10, 4), (7, 9), (5, 3) with last on the third; out_ready = 1.
  - Required: one cycle after the third beat, out_sum = 6, out_act = 01, out_trunc = 0.
- Zero and negative outcomes:
  - Single beat (4, 6), last → out_sum = −2, out_act = 00.
  - Next single beat (0, 22), last → out_sum = −22, out_act = 11. Results appear on consecutive cycles.
- Backpressure: complete a neuron with out_ready = 0, then drive further beats.
  - Required: in_ready = 0; acc is unchanged; the result holds for 5 cycles.
  - Raise out_ready in the same cycle as a new (3, 0) last beat. Required: out_sum = 3, out_act = 01, out_valid stays high.
- Forced close and saturation: 8 beats of (31, 0) with no in_last.
  - Required: at the 8th beat, out_sum = 248, out_act = 01, out_trunc = 1.
  - Repeat with ACC_W = 6: out_sum saturates at 31.
- Asynchronous reset mid-evaluation: accept 2 beats (20, 0), assert rst_n between clock edges, then release.
  - Required: outputs are immediately at reset values.
  - A following single beat (1, 0) last gives out_sum = 1, out_act = 00.

Source files
------------

// File: rtl/ternary_neuron_accum_if.sv
// Beat input and result output bundle for the ternary-neuron accumulator.
// slave = accumulator side, master = producer/consumer side.
interface ternary_neuron_accum_if #(
  parameter int CNT_W = 5,
  parameter int ACC_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [CNT_W-1:0] pos_cnt;
  logic [CNT_W-1:0] neg_cnt;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_act;
  logic [ACC_W-1:0] out_sum;
  logic             out_trunc;

  modport slave (
    input  in_valid, in_last, pos_cnt, neg_cnt, out_ready,
    output in_ready, out_valid, out_act, out_sum, out_trunc
  );

  modport master (
    output in_valid, in_last, pos_cnt, neg_cnt, out_ready,
    input  in_ready, out_valid, out_act, out_sum, out_trunc
  );
endinterface

// File: rtl/ternary_neuron_accum.sv
// Accumulates (pos_cnt - neg_cnt) over a multi-beat neuron with saturation,
// thresholds the final sum and holds a ternary result behind valid/ready.
module ternary_neuron_accum #(
  parameter int CNT_W     = 5,
  parameter int ACC_W     = 10,
  parameter int MAX_BEATS = 8,
  parameter int THR_HI    = 3,
  parameter int THR_LO    = -3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ternary_neuron_accum_if.slave  bus
);

  localparam int SUM_W = ((ACC_W > CNT_W + 1) ? ACC_W : CNT_W + 1) + 1;
  localparam int BC_W  = $clog2(MAX_BEATS + 1);

  localparam logic signed [SUM_W-1:0] SUM_MAX  = SUM_W'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SUM_MIN  = SUM_W'(-(1 << (ACC_W - 1)));
  localparam logic signed [ACC_W-1:0] THR_HI_V = ACC_W'(THR_HI);
  localparam logic signed [ACC_W-1:0] THR_LO_V = ACC_W'(THR_LO);
  localparam logic [BC_W-1:0]         LAST_CNT = BC_W'(MAX_BEATS - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [BC_W-1:0]          cnt_q, cnt_d;

  logic                     out_valid_q;
  logic [1:0]               out_act_q;
  logic [ACC_W-1:0]         out_sum_q;
  logic                     out_trunc_q;

  logic                     in_ready;
  logic                     accept;
  logic                     is_final;
  logic                     load;
  logic signed [CNT_W:0]    delta;
  logic signed [SUM_W-1:0]  sum_wide;
  logic signed [ACC_W-1:0]  sat_val;
  logic [1:0]               act_val;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign is_final = bus.in_last || (cnt_q == LAST_CNT);
  assign load     = accept && is_final;

  assign delta    = $signed({1'b0, bus.pos_cnt}) - $signed({1'b0, bus.neg_cnt});
  // Extra headroom bit so the clamp sees the true sum before it wraps.
  assign sum_wide = SUM_W'(acc_q) + SUM_W'(delta);

  always_comb begin
    sat_val = sum_wide[ACC_W-1:0];
    if (sum_wide > SUM_MAX) begin
      sat_val = {1'b0, {(ACC_W-1){1'b1}}};
    end else if (sum_wide < SUM_MIN) begin
      sat_val = {1'b1, {(ACC_W-1){1'b0}}};
    end
  end

  always_comb begin
    act_val = 2'b00;
    if (sat_val >= THR_HI_V) begin
      act_val = 2'b01;
    end else if (sat_val <= THR_LO_V) begin
      act_val = 2'b11;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && !is_final) begin
          state_d = ACCUM;
          acc_d   = sat_val;
          cnt_d   = BC_W'(1);
        end
      end
      ACCUM: begin
        if (accept) begin
          if (is_final) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = sat_val;
            cnt_d = cnt_q + BC_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data registers move only on a final beat; valid also clears on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_act_q   <= '0;
      out_sum_q   <= '0;
      out_trunc_q <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_act_q   <= act_val;
      out_sum_q   <= sat_val;
      out_trunc_q <= !bus.in_last;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_act   = out_act_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_trunc = out_trunc_q;

endmodule

// File: tb/tb_ternary_neuron_accum.sv
// Drives two accumulators (ACC_W 10 and 6) with identical beats and checks
// both against a transaction-level model of the neuron evaluation.
module tb_ternary_neuron_accum;

  localparam int MAX_BEATS = 8;
  localparam int THR_HI    = 3;
  localparam int THR_LO    = -3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ternary_neuron_accum_if #(.CNT_W(5), .ACC_W(10)) a_if ();
  ternary_neuron_accum_if #(.CNT_W(5), .ACC_W(6))  b_if ();

  ternary_neuron_accum #(
    .CNT_W(5), .ACC_W(10), .MAX_BEATS(MAX_BEATS), .THR_HI(THR_HI), .THR_LO(THR_LO)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));

  ternary_neuron_accum #(
    .CNT_W(5), .ACC_W(6), .MAX_BEATS(MAX_BEATS), .THR_HI(THR_HI), .THR_LO(THR_LO)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  int n_total = 0;
  int n_bad   = 0;

  int m_acc   [2];
  int m_cnt   [2];
  int m_valid [2];
  int m_sum   [2];
  int m_act   [2];
  int m_trunc [2];
  int acc_w   [2] = '{10, 6};

  task automatic tb_check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int x, input int w);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic int act_code(input int s);
    if (s >= THR_HI) return 1;
    if (s <= THR_LO) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_cnt[k] = 0; m_valid[k] = 0;
      m_sum[k] = 0; m_act[k] = 0; m_trunc[k] = 0;
    end
  endtask

  task automatic check_outputs();
    tb_check("a_valid", int'(a_if.out_valid), m_valid[0]);
    tb_check("a_sum",   int'($signed(a_if.out_sum)), m_sum[0]);
    tb_check("a_act",   int'(a_if.out_act), m_act[0]);
    tb_check("a_trunc", int'(a_if.out_trunc), m_trunc[0]);
    tb_check("b_valid", int'(b_if.out_valid), m_valid[1]);
    tb_check("b_sum",   int'($signed(b_if.out_sum)), m_sum[1]);
    tb_check("b_act",   int'(b_if.out_act), m_act[1]);
    tb_check("b_trunc", int'(b_if.out_trunc), m_trunc[1]);
  endtask

  // Entered and left on a falling edge; checks land 1 time unit after the rise.
  task automatic cycle(input bit v, input bit last, input int pos, input int neg, input bit ordy);
    bit acc_ok, fin;
    int s;
    a_if.in_valid = v;  a_if.in_last = last;  a_if.out_ready = ordy;
    a_if.pos_cnt = 5'(pos);  a_if.neg_cnt = 5'(neg);
    b_if.in_valid = v;  b_if.in_last = last;  b_if.out_ready = ordy;
    b_if.pos_cnt = 5'(pos);  b_if.neg_cnt = 5'(neg);
    #1;
    tb_check("a_in_ready", int'(a_if.in_ready), int'(m_valid[0] == 0 || ordy));
    tb_check("b_in_ready", int'(b_if.in_ready), int'(m_valid[1] == 0 || ordy));
    for (int k = 0; k < 2; k++) begin
      acc_ok = v && (m_valid[k] == 0 || ordy);
      if (acc_ok) begin
        s   = sat(m_acc[k] + pos - neg, acc_w[k]);
        fin = last || (m_cnt[k] == MAX_BEATS - 1);
        if (fin) begin
          m_valid[k] = 1;  m_sum[k] = s;  m_act[k] = act_code(s);
          m_trunc[k] = int'(!last);  m_acc[k] = 0;  m_cnt[k] = 0;
        end else begin
          m_acc[k] = s;  m_cnt[k]++;
          if (ordy) m_valid[k] = 0;
        end
      end else if (ordy) begin
        m_valid[k] = 0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    tb_check("rst_a_valid", int'(a_if.out_valid), 0);
    tb_check("rst_a_sum",   int'($signed(a_if.out_sum)), 0);
    tb_check("rst_a_act",   int'(a_if.out_act), 0);
    tb_check("rst_a_trunc", int'(a_if.out_trunc), 0);
    tb_check("rst_a_ready", int'(a_if.in_ready), 1);
    tb_check("rst_b_valid", int'(b_if.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    a_if.in_valid = 1'b0; a_if.in_last = 1'b0; a_if.out_ready = 1'b1;
    a_if.pos_cnt = '0; a_if.neg_cnt = '0;
    b_if.in_valid = 1'b0; b_if.in_last = 1'b0; b_if.out_ready = 1'b1;
    b_if.pos_cnt = '0; b_if.neg_cnt = '0;
    repeat (3) @(negedge clk);
    tb_check("reset_valid", int'(a_if.out_valid), 0);
    tb_check("reset_act",   int'(a_if.out_act), 0);
    tb_check("reset_sum",   int'($signed(a_if.out_sum)), 0);
    tb_check("reset_ready", int'(a_if.in_ready), 1);
    rst_n = 1'b1;
    repeat (2) cycle(0, 0, 0, 0, 1);

    // Three-beat positive evaluation
    cycle(1, 0, 10, 4, 1);
    cycle(1, 0, 7, 9, 1);
    cycle(1, 1, 5, 3, 1);
    tb_check("three_sum",   int'($signed(a_if.out_sum)), 6);
    tb_check("three_act",   int'(a_if.out_act), 1);
    tb_check("three_trunc", int'(a_if.out_trunc), 0);

    // Zero and negative single-beat outcomes on consecutive cycles
    cycle(1, 1, 4, 6, 1);
    tb_check("zero_sum", int'($signed(a_if.out_sum)), -2);
    tb_check("zero_act", int'(a_if.out_act), 0);
    cycle(1, 1, 0, 22, 1);
    tb_check("neg_sum",   int'($signed(a_if.out_sum)), -22);
    tb_check("neg_act",   int'(a_if.out_act), 3);
    tb_check("neg_valid", int'(a_if.out_valid), 1);

    // Backpressure: result of 4 must hold while beats are refused
    cycle(1, 0, 2, 0, 1);
    cycle(1, 1, 3, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, (i % 2) == 0, 17 + i, i, 0);
    tb_check("bp_hold_sum", int'($signed(a_if.out_sum)), 4);
    cycle(1, 1, 3, 0, 1);
    tb_check("bp_new_sum",   int'($signed(a_if.out_sum)), 3);
    tb_check("bp_new_act",   int'(a_if.out_act), 1);
    tb_check("bp_new_valid", int'(a_if.out_valid), 1);
    cycle(0, 0, 0, 0, 1);

    // Forced close at MAX_BEATS with saturation on the narrow instance
    for (int i = 0; i < MAX_BEATS; i++) cycle(1, 0, 31, 0, 1);
    tb_check("force_sum_a", int'($signed(a_if.out_sum)), 248);
    tb_check("force_act_a", int'(a_if.out_act), 1);
    tb_check("force_trunc", int'(a_if.out_trunc), 1);
    tb_check("force_sum_b", int'($signed(b_if.out_sum)), 31);

    // Asynchronous reset mid-evaluation
    cycle(1, 0, 20, 0, 1);
    cycle(1, 0, 20, 0, 1);
    async_reset_pulse();
    cycle(1, 1, 1, 0, 1);
    tb_check("post_rst_sum", int'($signed(a_if.out_sum)), 1);
    tb_check("post_rst_act", int'(a_if.out_act), 0);

    // Randomized traffic including stalls and frequent negative saturation
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(3) != 0), ($urandom_range(3) == 0),
            int'($urandom_range(31)), int'($urandom_range(31)),
            ($urandom_range(2) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
